// File: rtl/collision_probe_pkg.sv
// Shared definitions for the collision probe slice.
//   - default geometry (tile size, map size, legal pixel window)
//   - FSM state encoding and probe index type
//   - edge ordering of the four blocked flags and the probe -> edge mapping
package collision_probe_pkg;

   localparam int DEF_TILE_SHIFT = 4;
   localparam int DEF_MAP_W      = 40;
   localparam int DEF_MAP_H      = 30;
   localparam int DEF_X_MAX      = 639;
   localparam int DEF_Y_MAX      = 479;

   localparam int BALL_W  = 10;
   // Wide enough that X+S+1 and X-S-1 never wrap for 10-bit inputs.
   localparam int COORD_W = 12;
   typedef logic signed [COORD_W-1:0] coord_t;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_PROBE = 2'd1;
   localparam state_t ST_DRAIN = 2'd2;
   localparam state_t ST_DONE  = 2'd3;

   typedef logic [2:0] probe_idx_t;
   localparam probe_idx_t PROBE_LAST = 3'd7;

   // Probes come in pairs: 0,1 down; 2,3 up; 4,5 left; 6,7 right.
   typedef logic [1:0] edge_t;
   localparam edge_t EDGE_DOWN  = 2'd0;
   localparam edge_t EDGE_UP    = 2'd1;
   localparam edge_t EDGE_LEFT  = 2'd2;
   localparam edge_t EDGE_RIGHT = 2'd3;

   function automatic edge_t probe_edge(probe_idx_t idx);
      return idx[2:1];
   endfunction

endpackage

// File: rtl/collision_probe_if.sv
// Request/result bundle of the collision probe.
//   master : requester (drives start and ball geometry, reads flags)
//   slave  : collision_probe itself
//   start             request one probe pass
//   BallX/BallY/BallS ball centre and half-size in pixels
//   up/left/right/down registered blocked flags
//   busy / done       pass in progress / one-cycle completion pulse
interface collision_probe_if;
   import collision_probe_pkg::*;

   logic              start;
   logic [BALL_W-1:0] BallX;
   logic [BALL_W-1:0] BallY;
   logic [BALL_W-1:0] BallS;
   logic              up;
   logic              left;
   logic              right;
   logic              down;
   logic              busy;
   logic              done;

   modport master (
      output start, BallX, BallY, BallS,
      input  up, left, right, down, busy, done
   );

   modport slave (
      input  start, BallX, BallY, BallS,
      output up, left, right, down, busy, done
   );

endinterface

// File: rtl/collision_probe_tile_map_rom.sv
// Tile map storage: DEPTH x 1 bit, one solid bit per tile, registered read
// (data valid the cycle after addr). The map starts empty.
//   frame_clk  clock
//   addr       tile address, row-major
//   data       registered solid bit
module tile_map_rom #(
   parameter int    DEPTH     = 1200,
   parameter int    AW        = 11,
   parameter string INIT_FILE = ""
) (
   input  logic          frame_clk,
   input  logic [AW-1:0] addr,
   output logic          data
);

   logic mem [DEPTH];

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = 1'b0;
   end

   always_ff @(posedge frame_clk) begin
      data <= mem[addr];
   end

endmodule

// File: rtl/collision_probe.sv
// Ball-versus-tile-map collision probe. On start, latches the ball position,
// samples eight pixels just outside the ball's bounding box (two per edge),
// and updates the four blocked flags together once all eight are resolved.
// Pixels outside the legal screen window count as solid.
//   frame_clk  clock
//   Reset      asynchronous, active-high reset
//   bus        collision_probe_if.slave (start, ball geometry, flags, busy, done)
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting for start; flags hold the last completed pass
// ST_PROBE | issuing probe idx (0..7), one per cycle
// ST_DRAIN | last probe's map data in flight, being accumulated
// ST_DONE  | publish accumulated flags, pulse done, drop busy
module collision_probe
   import collision_probe_pkg::*;
#(
   parameter int    TILE_SHIFT    = DEF_TILE_SHIFT,
   parameter int    MAP_W         = DEF_MAP_W,
   parameter int    MAP_H         = DEF_MAP_H,
   parameter int    X_MAX         = DEF_X_MAX,
   parameter int    Y_MAX         = DEF_Y_MAX,
   parameter string MAP_INIT_FILE = ""
) (
   input  logic             frame_clk,
   input  logic             Reset,
   collision_probe_if.slave bus
);

   localparam int     MAP_DEPTH = MAP_W * MAP_H;
   localparam int     MAP_AW    = (MAP_DEPTH > 1) ? $clog2(MAP_DEPTH) : 1;
   localparam coord_t X_LIM     = coord_t'(X_MAX);
   localparam coord_t Y_LIM     = coord_t'(Y_MAX);

   state_t            state;
   probe_idx_t        idx;
   probe_idx_t        idx_q;
   logic [BALL_W-1:0] bx, by, bs;
   logic              valid_q;
   logic              oor_q;
   logic [3:0]        acc;
   logic [3:0]        flags;
   logic              busy_r;
   logic              done_r;

   coord_t cx, cy, cs;
   coord_t x_in_lo, x_in_hi, x_out_lo, x_out_hi;
   coord_t y_in_lo, y_in_hi, y_out_lo, y_out_hi;
   coord_t px, py;
   logic   probe_oor;
   logic   rom_data;
   logic [COORD_W-1:0] tile_x, tile_y;
   logic [MAP_AW-1:0]  rom_addr;

   assign cx = coord_t'({2'b00, bx});
   assign cy = coord_t'({2'b00, by});
   assign cs = coord_t'({2'b00, bs});

   assign x_in_lo  = cx - cs;
   assign x_in_hi  = cx + cs;
   assign x_out_lo = cx - cs - coord_t'(1);
   assign x_out_hi = cx + cs + coord_t'(1);
   assign y_in_lo  = cy - cs;
   assign y_in_hi  = cy + cs;
   assign y_out_lo = cy - cs - coord_t'(1);
   assign y_out_hi = cy + cs + coord_t'(1);

   always_comb begin
      px = x_in_lo;
      py = y_out_hi;
      case (idx)
         3'd0: begin px = x_in_lo;  py = y_out_hi; end
         3'd1: begin px = x_in_hi;  py = y_out_hi; end
         3'd2: begin px = x_in_lo;  py = y_out_lo; end
         3'd3: begin px = x_in_hi;  py = y_out_lo; end
         3'd4: begin px = x_out_lo; py = y_in_lo;  end
         3'd5: begin px = x_out_lo; py = y_in_hi;  end
         3'd6: begin px = x_out_hi; py = y_in_lo;  end
         default: begin px = x_out_hi; py = y_in_hi; end
      endcase
   end

   assign probe_oor = px[COORD_W-1] | py[COORD_W-1] | (px > X_LIM) | (py > Y_LIM);

   // Only meaningful when in range (non-negative); address forced to 0 otherwise.
   assign tile_x   = $unsigned(px) >> TILE_SHIFT;
   assign tile_y   = $unsigned(py) >> TILE_SHIFT;
   assign rom_addr = probe_oor ? '0
                   : MAP_AW'(32'(tile_y) * 32'(MAP_W) + 32'(tile_x));

   tile_map_rom #(
      .DEPTH     (MAP_DEPTH),
      .AW        (MAP_AW),
      .INIT_FILE (MAP_INIT_FILE)
   ) u_rom (
      .frame_clk (frame_clk),
      .addr      (rom_addr),
      .data      (rom_data)
   );

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         state   <= ST_IDLE;
         idx     <= '0;
         idx_q   <= '0;
         bx      <= '0;
         by      <= '0;
         bs      <= '0;
         valid_q <= 1'b0;
         oor_q   <= 1'b0;
         acc     <= '0;
         flags   <= '0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         // Out-of-range decision travels alongside the ROM read so both
         // land in the same cycle.
         valid_q <= (state == ST_PROBE);
         idx_q   <= idx;
         oor_q   <= probe_oor;
         done_r  <= 1'b0;

         if (valid_q) begin
            acc[probe_edge(idx_q)] <= acc[probe_edge(idx_q)] | oor_q | rom_data;
         end

         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  bx     <= bus.BallX;
                  by     <= bus.BallY;
                  bs     <= bus.BallS;
                  idx    <= '0;
                  acc    <= '0;
                  busy_r <= 1'b1;
                  state  <= ST_PROBE;
               end
            end
            ST_PROBE: begin
               idx <= idx + 3'd1;
               if (idx == PROBE_LAST) state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               state <= ST_DONE;
            end
            default: begin
               flags  <= acc;
               done_r <= 1'b1;
               busy_r <= 1'b0;
               state  <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.down  = flags[EDGE_DOWN];
   assign bus.up    = flags[EDGE_UP];
   assign bus.left  = flags[EDGE_LEFT];
   assign bus.right = flags[EDGE_RIGHT];
   assign bus.busy  = busy_r;
   assign bus.done  = done_r;

endmodule

// File: tb/tb_collision_probe.sv
// Bench for collision_probe: directed passes with hand-computed flags,
// plus a pixel-level reference model checked every cycle.
// Flag vectors below are written {up, left, right, down}.
module tb_collision_probe;
   import collision_probe_pkg::*;

   logic frame_clk = 1'b0;
   logic Reset     = 1'b0;
   bit   checking  = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;

   bit tb_map [0:1199];

   collision_probe_if cp_bus ();

   collision_probe #(
      .TILE_SHIFT (4),
      .MAP_W      (40),
      .MAP_H      (30),
      .X_MAX      (639),
      .Y_MAX      (479)
   ) dut (
      .frame_clk (frame_clk),
      .Reset     (Reset),
      .bus       (cp_bus)
   );

   always #5 frame_clk = ~frame_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic bit solid(int px, int py);
      if (px < 0 || px > 639 || py < 0 || py > 479) return 1'b1;
      return tb_map[(py / 16) * 40 + (px / 16)];
   endfunction

   function automatic logic [3:0] expect_flags(int x, int y, int s);
      logic [3:0] f;
      f[0] = solid(x - s, y + s + 1)     | solid(x + s, y + s + 1);
      f[3] = solid(x - s, y - s - 1)     | solid(x + s, y - s - 1);
      f[2] = solid(x - s - 1, y - s)     | solid(x - s - 1, y + s);
      f[1] = solid(x + s + 1, y - s)     | solid(x + s + 1, y + s);
      return f;
   endfunction

   function automatic logic [3:0] dut_flags();
      return {cp_bus.up, cp_bus.left, cp_bus.right, cp_bus.down};
   endfunction

   // A pass occupies 10 edges after acceptance; flags, done and busy change
   // together on the last of them.
   int         m_cnt     = 0;
   bit         m_busy    = 1'b0;
   bit         m_done    = 1'b0;
   logic [3:0] m_flags   = 4'b0;
   logic [3:0] m_pending = 4'b0;

   always @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         m_cnt  = 0;
         m_busy = 1'b0;
         m_done = 1'b0;
         m_flags = 4'b0;
      end else begin
         m_done = 1'b0;
         if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
               m_flags = m_pending;
               m_done  = 1'b1;
               m_busy  = 1'b0;
            end
         end else if (cp_bus.start) begin
            m_pending = expect_flags(int'(cp_bus.BallX), int'(cp_bus.BallY), int'(cp_bus.BallS));
            m_cnt     = 10;
            m_busy    = 1'b1;
         end
      end
   end

   always @(negedge frame_clk) begin
      if (checking) begin
         check("cyc_busy",  32'(cp_bus.busy), 32'(m_busy));
         check("cyc_done",  32'(cp_bus.done), 32'(m_done));
         check("cyc_flags", 32'(dut_flags()), 32'(m_flags));
      end
   end

   // ---------------- stimulus ----------------
   task automatic set_tile(int tx, int ty, bit v);
      tb_map[ty * 40 + tx] = v;
      dut.u_rom.mem[ty * 40 + tx] = v;
   endtask

   task automatic drive_ball(int x, int y, int s);
      cp_bus.BallX = 10'(x);
      cp_bus.BallY = 10'(y);
      cp_bus.BallS = 10'(s);
   endtask

   task automatic scramble();
      cp_bus.BallX = 10'($urandom_range(0, 1023));
      cp_bus.BallY = 10'($urandom_range(0, 1023));
      cp_bus.BallS = 10'($urandom_range(0, 1023));
   endtask

   // Waits up to 20 negedges for done; returns the negedge count (0 = timeout).
   task automatic wait_done(output int lat);
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge frame_clk);
         if (cp_bus.done) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic run_pass(input string name, input int x, input int y, input int s,
                           input logic [3:0] exp_lit);
      int lat;
      @(posedge frame_clk); #1;
      drive_ball(x, y, s);
      cp_bus.start = 1'b1;
      @(posedge frame_clk); #1;   // E0
      cp_bus.start = 1'b0;
      scramble();
      wait_done(lat);
      check({name, "_latency"}, 32'(lat), 32'd11);
      check({name, "_flags"},   32'(dut_flags()), 32'(exp_lit));
      check({name, "_model"},   32'(expect_flags(x, y, s)), 32'(exp_lit));
   endtask

   initial begin
      int lat;
      int n_done;
      cp_bus.start = 1'b0;
      drive_ball(0, 0, 0);
      for (int i = 0; i < 1200; i++) tb_map[i] = 1'b0;

      #2 Reset = 1'b1;
      checking = 1'b1;
      repeat (3) @(posedge frame_clk);
      #1;
      check("reset_flags", 32'(dut_flags()), 32'd0);
      check("reset_busy",  32'(cp_bus.busy), 32'd0);
      check("reset_done",  32'(cp_bus.done), 32'd0);
      Reset = 1'b0;

      // empty map
      run_pass("centre",     320, 240, 4, 4'b0000);
      run_pass("bottom_oor", 320, 475, 4, 4'b0001);
      run_pass("left_oor",     4, 100, 4, 4'b0100);
      run_pass("right_oor",  635, 100, 4, 4'b0010);
      run_pass("s0_topleft",   0,   0, 0, 4'b1100);
      run_pass("s0_botright", 639, 479, 0, 4'b0011);
      run_pass("clear_again", 320, 240, 4, 4'b0000);

      // second start inside a pass is dropped
      @(posedge frame_clk); #1;
      drive_ball(320, 475, 4);
      cp_bus.start = 1'b1;
      @(posedge frame_clk); #1;   // E0
      cp_bus.start = 1'b0;
      @(posedge frame_clk);       // E1
      @(posedge frame_clk); #1;   // E2
      drive_ball(4, 100, 4);
      cp_bus.start = 1'b1;
      @(posedge frame_clk); #1;   // E3
      cp_bus.start = 1'b0;
      wait_done(lat);
      check("ignore_latency", 32'(lat), 32'd8);
      check("ignore_flags",   32'(dut_flags()), 32'b0001);
      @(negedge frame_clk);
      check("ignore_busy_after", 32'(cp_bus.busy), 32'd0);
      check("ignore_no_second_done", 32'(cp_bus.done), 32'd0);

      run_pass("clear_before_abort", 320, 240, 4, 4'b0000);

      // reset in the middle of a pass that would set down
      @(posedge frame_clk); #1;
      drive_ball(320, 475, 4);
      cp_bus.start = 1'b1;
      @(posedge frame_clk); #1;   // E0
      cp_bus.start = 1'b0;
      repeat (5) @(posedge frame_clk);
      #1 Reset = 1'b1;            // just after E5
      @(posedge frame_clk); #1;
      Reset = 1'b0;
      n_done = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge frame_clk);
         if (cp_bus.done) n_done++;
      end
      check("abort_no_done", 32'(n_done), 32'd0);
      check("abort_flags",   32'(dut_flags()), 32'd0);
      check("abort_busy",    32'(cp_bus.busy), 32'd0);
      run_pass("after_abort", 320, 475, 4, 4'b0001);

      // one solid tile covering pixels x 320..335, y 240..255
      set_tile(20, 15, 1'b1);
      run_pass("tile_below", 328, 235, 4, 4'b0001);
      run_pass("tile_above", 328, 260, 4, 4'b1000);
      run_pass("tile_left",  340, 248, 4, 4'b0100);
      run_pass("tile_none",  100, 100, 4, 4'b0000);

      repeat (2) @(negedge frame_clk);
      checking = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/collision_probe.md
COLLISION_PROBE -- requirements
Module: collision_probe

Interface
REQ-001 SHALL have parameter TILE_SHIFT, default 4, meaning tile edge is 2^TILE_SHIFT pixels.
REQ-002 SHALL have parameter MAP_W, default 40, meaning map width in tiles.
REQ-003 SHALL have parameter MAP_H, default 30, meaning map height in tiles.
REQ-004 SHALL have parameter X_MAX, default 639, meaning rightmost legal pixel column.
REQ-005 SHALL have parameter Y_MAX, default 479, meaning bottommost legal pixel row.
REQ-006 frame_clk  input  1  clock; all state changes on its rising edge.
REQ-007 Reset  input  1  asynchronous, active-high reset.
REQ-008 start  input  1  request one probe pass on the current ball position.
REQ-009 BallX  input  10  ball center X, pixels.
REQ-010 BallY  input  10  ball center Y, pixels.
REQ-011 BallS  input  10  ball half-size, pixels.
REQ-012 up, left, right, down  output  1 each  registered blocked flags: solid pixel adjacent to that ball edge.
REQ-013 busy  output  1  high while a pass is in progress.
REQ-014 done  output  1  one-cycle pulse when flags are updated.

Function
REQ-015 SHALL implement FSM IDLE -> PROBE -> DRAIN -> DONE -> IDLE.
REQ-016 In IDLE, start=1 SHALL latch BallX/BallY/BallS on that edge (E0), clear probe index, enter PROBE.
REQ-017 start while not IDLE SHALL be ignored, with no queuing.
REQ-018 Probes in order 0..7: down (X-S,Y+S+1), (X+S,Y+S+1); up (X-S,Y-S-1), (X+S,Y-S-1); left (X-S-1,Y-S), (X-S-1,Y+S); right (X+S+1,Y-S), (X+S+1,Y+S).
REQ-019 Probe coordinates SHALL be computed in 12-bit signed arithmetic; no 10-bit wrap allowed.
REQ-020 A probe with x<0, x>X_MAX, y<0 or y>Y_MAX SHALL count solid without a map read.
REQ-021 In-range probe SHALL read map at address (y>>TILE_SHIFT)*MAP_W + (x>>TILE_SHIFT); map read latency exactly 1 cycle.
REQ-022 One probe SHALL be issued per cycle, edges E1..E8; results are accumulated as E2..E9.
REQ-023 Each flag SHALL be the OR of its two probe results.
REQ-024 up/left/right/down SHALL update simultaneously on edge E10, and done SHALL be high for exactly the cycle following E10.
REQ-025 Flags SHALL hold prior values between updates; no partial result visible.
REQ-026 busy SHALL be high from E0 until E10, then low; a new start is acceptable at edge E11.
REQ-027 Input changes after E0 SHALL not affect the current pass.
REQ-028 BallS=0 SHALL be legal, with both probes of an edge coinciding.

Reset
REQ-029 Reset SHALL force IDLE, up=left=right=down=0, busy=0, done=0, and clear the accumulators, asynchronously.
REQ-030 Reset mid-pass SHALL abort the pass; no done and no flag update follow its release.
REQ-031 After Reset deasserts, the first start SHALL be accepted normally.

Structure
REQ-032 A shared package SHALL hold the FSM state enum, probe-index type, TILE_SHIFT/MAP_W/MAP_H/X_MAX/Y_MAX defaults, and edge-order constants.
REQ-033 Map storage SHALL be sub-module tile_map_rom: MAP_W*MAP_H x 1 bit, registered read, contents from an init file.
REQ-034 Out-of-range decision SHALL be pipelined one cycle so it aligns with the ROM data.

Verification
REQ-035 Empty map, ball (320,240) S=4, start -> after 10 cycles done=1, all flags 0.
REQ-036 Empty map, ball (320,475) S=4 -> down=1 (y=480 out of range), up=left=right=0.
REQ-037 Empty map, ball (4,100) S=4 -> left=1 (x=-1), others 0; ball (635,100) -> right=1.
REQ-038 Tile (20,15) solid, ball (328,235) S=4 -> down=1 only; ball (328,260) S=4 -> up=1 only.
REQ-039 start pulsed again at E3 with a different position -> ignored; flags reflect the E0 position; busy low after E10.
REQ-040 Reset asserted at E5 of a pass giving down=1 -> flags stay 0, no done, busy=0; next start completes normally.
